// File: rtl/exec_unit_dtypes.sv
// Shared exec-unit datatypes for the alpu operand xbuf arbiter.
// Optional feature macro: ALPU_XBUF_ARB_PERF_EN (perf counter width lives here).
package exec_unit_dtypes;

    localparam int EXEC_UNIT_ADDR_W = 8;
    localparam int EXEC_UNIT_DATA_W = 32;
    localparam int XBUF_OWNER_W     = 4;   // supports up to 16 write requesters
    localparam int XBUF_PERF_W      = 16;

    typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

    // One-entry write staging slot
    typedef struct packed {
        logic                    valid;
        logic [XBUF_OWNER_W-1:0] owner;
        type_exec_unit_addr      addr;
        type_exec_unit_data      data;
    } type_xbuf_wr_slot;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } type_xbuf_wstate;

    // Saturating increment for the perf counters
    function automatic logic [XBUF_PERF_W-1:0] perf_sat_inc(input logic [XBUF_PERF_W-1:0] v);
        return (v == {XBUF_PERF_W{1'b1}}) ? v : v + XBUF_PERF_W'(1);
    endfunction

endpackage

// File: rtl/alpu_rr_arb.sv
// Combinational round-robin arbiter: search for the first set request starting at ptr.
module alpu_rr_arb #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic found_s;
    int   pos_s;

    // Rotating priority search, lowest distance from ptr wins
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < N; i++) begin
            pos_s = (int'(ptr) + i) % N;
            if (!found_s && req[pos_s]) begin
                found_s    = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = pos_s[W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alpu_xbuf_arb.sv
// alpu operand xbuf arbiter: NUM_WR producers / NUM_RD consumers onto one
// write port and one read port, with a registered write staging slot and
// read/write address collision masking.
// Optional feature macro: ALPU_XBUF_ARB_PERF_EN adds saturating perf counters.
module alpu_xbuf_arb
    import exec_unit_dtypes::*;
#(
    parameter int NUM_WR    = 4,
    parameter int NUM_RD    = 2,
    parameter int STALL_MAX = 15
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_WR-1:0]                   wreq_i,
    input  type_exec_unit_addr [NUM_WR-1:0]     waddr_i,
    input  type_exec_unit_data [NUM_WR-1:0]     wdata_i,
    output logic [NUM_WR-1:0]                   wack_o,
    input  logic [NUM_RD-1:0]                   rreq_i,
    input  type_exec_unit_addr [NUM_RD-1:0]     raddr_i,
    output logic [NUM_RD-1:0]                   rgnt_o,
    output logic [NUM_RD-1:0]                   rresp_o,
    output logic                                rhit_o,
    output type_exec_unit_data                  rdata_o,
    output logic                                werr_o,
`ifdef ALPU_XBUF_ARB_PERF_EN
    output logic [XBUF_PERF_W-1:0]              perf_wacc_o,
    output logic [XBUF_PERF_W-1:0]              perf_wstall_o,
    output logic [XBUF_PERF_W-1:0]              perf_rmiss_o,
    output logic [XBUF_PERF_W-1:0]              perf_rcoll_o,
`endif
    output type_exec_unit_addr                  xb_waddr_o,
    output type_exec_unit_data                  xb_wdata_o,
    output logic                                xb_wvalid_o,
    input  logic                                xb_wready_i,
    output type_exec_unit_addr                  xb_raddr_o,
    output logic                                xb_rvalid_o,
    input  type_exec_unit_data                  xb_rdata_i,
    input  logic                                xb_rhit_i
);

    localparam int WR_IW = $clog2(NUM_WR);
    localparam int RD_IW = $clog2(NUM_RD);
    localparam int SC_W  = $clog2(STALL_MAX + 1);

    type_xbuf_wstate   wstate_r, wstate_nxt_s;
    type_xbuf_wr_slot  slot_r, slot_nxt_s;
    logic [WR_IW-1:0]  wptr_r, wptr_nxt_s, warb_ptr_s, widx_s, owner_nxt_s;
    logic [RD_IW-1:0]  rptr_r, rptr_nxt_s, ridx_s;
    logic [SC_W-1:0]   stall_cnt_r, stall_nxt_s;
    logic              werr_r, werr_nxt_s;
    logic              rdy_r;
    logic [NUM_RD-1:0] rresp_r;
    logic [NUM_WR-1:0] warb_req_s, wgnt_s, owner_oh_s, wack_s;
    logic [NUM_RD-1:0] coll_s, rarb_req_s, rgnt_s;
    logic              busy_s, w_acc_s;

    assign busy_s  = (wstate_r == W_BUSY);
    assign w_acc_s = busy_s & xb_wready_i;

    // Owner decode and the post-accept search start (owner + 1 mod NUM_WR)
    always_comb begin
        owner_oh_s = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            owner_oh_s[i] = busy_s && (slot_r.owner == XBUF_OWNER_W'(i));
        end
        if (slot_r.owner == XBUF_OWNER_W'(NUM_WR - 1)) begin
            owner_nxt_s = '0;
        end else begin
            owner_nxt_s = WR_IW'(slot_r.owner + 1'b1);
        end
    end

    // Write arbiter inputs: free slot, or back-to-back reload excluding the owner
    always_comb begin
        warb_req_s = '0;
        warb_ptr_s = wptr_r;
        if (!busy_s) begin
            warb_req_s = wreq_i;
        end else if (w_acc_s) begin
            warb_req_s = wreq_i & ~owner_oh_s;
            warb_ptr_s = owner_nxt_s;
        end else begin
            warb_req_s = '0;
        end
    end

    alpu_rr_arb #(.N(NUM_WR), .W(WR_IW)) u_warb (
        .req (warb_req_s),
        .ptr (warb_ptr_s),
        .gnt (wgnt_s),
        .idx (widx_s)
    );

    // Write FSM next state, slot load, stall counting and sticky error
    always_comb begin
        wstate_nxt_s = wstate_r;
        slot_nxt_s   = slot_r;
        wptr_nxt_s   = wptr_r;
        stall_nxt_s  = stall_cnt_r;
        werr_nxt_s   = werr_r;
        wack_s       = '0;
        case (wstate_r)
            W_IDLE: begin
                if (|warb_req_s) begin
                    slot_nxt_s.valid = 1'b1;
                    slot_nxt_s.owner = XBUF_OWNER_W'(widx_s);
                    slot_nxt_s.addr  = waddr_i[widx_s];
                    slot_nxt_s.data  = wdata_i[widx_s];
                    wstate_nxt_s     = W_BUSY;
                end else begin
                    wstate_nxt_s = W_IDLE;
                end
            end
            W_BUSY: begin
                if (xb_wready_i) begin
                    wack_s      = owner_oh_s;
                    wptr_nxt_s  = owner_nxt_s;
                    stall_nxt_s = '0;
                    if (|warb_req_s) begin
                        slot_nxt_s.valid = 1'b1;
                        slot_nxt_s.owner = XBUF_OWNER_W'(widx_s);
                        slot_nxt_s.addr  = waddr_i[widx_s];
                        slot_nxt_s.data  = wdata_i[widx_s];
                        wstate_nxt_s     = W_BUSY;
                    end else begin
                        slot_nxt_s   = '0;
                        wstate_nxt_s = W_IDLE;
                    end
                end else begin
                    if (stall_cnt_r != SC_W'(STALL_MAX)) begin
                        stall_nxt_s = stall_cnt_r + 1'b1;
                    end else begin
                        stall_nxt_s = stall_cnt_r;
                    end
                    if (stall_nxt_s == SC_W'(STALL_MAX)) begin
                        werr_nxt_s = 1'b1;
                    end else begin
                        werr_nxt_s = werr_r;
                    end
                end
            end
            default: begin
                wstate_nxt_s = W_IDLE;
                slot_nxt_s   = '0;
            end
        endcase
    end

    // Reads are masked when they target the address the slot is writing
    always_comb begin
        coll_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            coll_s[i] = rreq_i[i] && busy_s && (raddr_i[i] == slot_r.addr);
        end
        if (rdy_r) begin
            rarb_req_s = rreq_i & ~coll_s;
        end else begin
            rarb_req_s = '0;
        end
    end

    alpu_rr_arb #(.N(NUM_RD), .W(RD_IW)) u_rarb (
        .req (rarb_req_s),
        .ptr (rptr_r),
        .gnt (rgnt_s),
        .idx (ridx_s)
    );

    // Read issue: address mux and next read pointer
    always_comb begin
        if (|rgnt_s) begin
            xb_raddr_o = raddr_i[ridx_s];
            if (ridx_s == RD_IW'(NUM_RD - 1)) begin
                rptr_nxt_s = '0;
            end else begin
                rptr_nxt_s = ridx_s + 1'b1;
            end
        end else begin
            xb_raddr_o = '0;
            rptr_nxt_s = rptr_r;
        end
    end

    // State, slot, pointers, stall counter, error flag and read tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_r    <= W_IDLE;
            slot_r      <= '0;
            wptr_r      <= '0;
            rptr_r      <= '0;
            stall_cnt_r <= '0;
            werr_r      <= 1'b0;
            rresp_r     <= '0;
            rdy_r       <= 1'b0;
        end else begin
            wstate_r    <= wstate_nxt_s;
            slot_r      <= slot_nxt_s;
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            stall_cnt_r <= stall_nxt_s;
            werr_r      <= werr_nxt_s;
            rresp_r     <= rgnt_s;
            rdy_r       <= 1'b1;
        end
    end

    assign wack_o      = wack_s;
    assign werr_o      = werr_r;
    assign xb_wvalid_o = slot_r.valid;
    assign xb_waddr_o  = slot_r.addr;
    assign xb_wdata_o  = slot_r.data;
    assign rgnt_o      = rgnt_s;
    assign xb_rvalid_o = |rgnt_s;
    assign rresp_o     = rresp_r;
    assign rhit_o      = (|rresp_r) & xb_rhit_i;
    assign rdata_o     = (|rresp_r) ? xb_rdata_i : '0;

`ifdef ALPU_XBUF_ARB_PERF_EN
    logic [XBUF_PERF_W-1:0] perf_wacc_r, perf_wstall_r, perf_rmiss_r, perf_rcoll_r;

    // Saturating event counters; collisions count one per cycle with any masked read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_wacc_r   <= '0;
            perf_wstall_r <= '0;
            perf_rmiss_r  <= '0;
            perf_rcoll_r  <= '0;
        end else begin
            if (w_acc_s)                    perf_wacc_r   <= perf_sat_inc(perf_wacc_r);
            if (busy_s && !xb_wready_i)     perf_wstall_r <= perf_sat_inc(perf_wstall_r);
            if ((|rresp_r) && !xb_rhit_i)   perf_rmiss_r  <= perf_sat_inc(perf_rmiss_r);
            if (rdy_r && (|coll_s))         perf_rcoll_r  <= perf_sat_inc(perf_rcoll_r);
        end
    end

    assign perf_wacc_o   = perf_wacc_r;
    assign perf_wstall_o = perf_wstall_r;
    assign perf_rmiss_o  = perf_rmiss_r;
    assign perf_rcoll_o  = perf_rcoll_r;
`endif

endmodule

// File: tb/tb_alpu_xbuf_arb.sv
// Directed self-checking bench for alpu_xbuf_arb (NUM_WR=4, NUM_RD=2, STALL_MAX=15).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_alpu_xbuf_arb;
    import exec_unit_dtypes::*;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [3:0]             wreq;
    type_exec_unit_addr [3:0] waddr;
    type_exec_unit_data [3:0] wdata;
    logic [3:0]             wack;
    logic [1:0]             rreq, rgnt, rresp;
    type_exec_unit_addr [1:0] raddr;
    logic                   rhit, werr, xb_wvalid, xb_wready, xb_rvalid, xb_rhit;
    type_exec_unit_data     rdata, xb_wdata, xb_rdata;
    type_exec_unit_addr     xb_waddr, xb_raddr;
`ifdef ALPU_XBUF_ARB_PERF_EN
    logic [15:0] p_wacc, p_wstall, p_rmiss, p_rcoll;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alpu_xbuf_arb dut (
        .clk(clk), .reset_n(reset_n),
        .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wack_o(wack),
        .rreq_i(rreq), .raddr_i(raddr), .rgnt_o(rgnt), .rresp_o(rresp),
        .rhit_o(rhit), .rdata_o(rdata), .werr_o(werr),
`ifdef ALPU_XBUF_ARB_PERF_EN
        .perf_wacc_o(p_wacc), .perf_wstall_o(p_wstall),
        .perf_rmiss_o(p_rmiss), .perf_rcoll_o(p_rcoll),
`endif
        .xb_waddr_o(xb_waddr), .xb_wdata_o(xb_wdata), .xb_wvalid_o(xb_wvalid),
        .xb_wready_i(xb_wready), .xb_raddr_o(xb_raddr), .xb_rvalid_o(xb_rvalid),
        .xb_rdata_i(xb_rdata), .xb_rhit_i(xb_rhit)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".wack"},   64'(wack),      64'h0);
        chk({tag, ".wvalid"}, 64'(xb_wvalid), 64'h0);
        chk({tag, ".waddr"},  64'(xb_waddr),  64'h0);
        chk({tag, ".werr"},   64'(werr),      64'h0);
        chk({tag, ".rgnt"},   64'(rgnt),      64'h0);
        chk({tag, ".rresp"},  64'(rresp),     64'h0);
        chk({tag, ".rdata"},  64'(rdata),     64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; wreq = 4'h0; rreq = 2'b00; xb_wready = 1'b0;
        xb_rhit = 1'b0; xb_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            waddr[i] = 8'h10 + 8'(i);
            wdata[i] = 32'hA000_0000 + 32'(i);
        end
        raddr[0] = 8'h05; raddr[1] = 8'h06;
        #23;
        chk_idle_outputs("reset");
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // ---- four producers back to back, 1 write per cycle ----
        @(negedge clk); wreq = 4'hF; xb_wready = 1'b1; #1;
        chk("wr.first_wvalid", 64'(xb_wvalid), 64'h0);
        chk("wr.first_wack",   64'(wack),      64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); wreq = 4'(4'hF << k); #1;
            chk("wr.wvalid", 64'(xb_wvalid), 64'h1);
            chk("wr.wack",   64'(wack),      64'(4'b0001 << k));
            chk("wr.waddr",  64'(xb_waddr),  64'(8'h10 + 8'(k)));
            chk("wr.wdata",  64'(xb_wdata),  64'(32'hA000_0000 + 32'(k)));
        end
        @(negedge clk); wreq = 4'h0; #1;
        chk("wr.drain_wvalid", 64'(xb_wvalid), 64'h0);

        // ---- owner 2 stalled 16 cycles, error flag after the 15th ----
        @(negedge clk); wreq = 4'b0100; xb_wready = 1'b0; #1;
        chk("stall.load_wack", 64'(wack), 64'h0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #1;
            chk("stall.waddr", 64'(xb_waddr),  64'h12);
            chk("stall.wdata", 64'(xb_wdata),  64'hA000_0002);
            chk("stall.wack",  64'(wack),      64'h0);
            chk("stall.werr",  64'(werr),      (k >= 16) ? 64'h1 : 64'h0);
        end
        @(negedge clk); xb_wready = 1'b1; #1;
        chk("stall.release_wack", 64'(wack), 64'h4);
        chk("stall.release_werr", 64'(werr), 64'h1);
        @(negedge clk); wreq = 4'h0; #1;
        chk("stall.sticky_werr", 64'(werr), 64'h1);
        chk("stall.idle_wvalid", 64'(xb_wvalid), 64'h0);

        // ---- read masked by slot address (wptr=3, so producer 0 loads) ----
        waddr[0] = 8'h05;
        @(negedge clk); wreq = 4'b0001; xb_wready = 1'b0;
        @(negedge clk); rreq = 2'b11; #1;
        chk("coll.waddr",  64'(xb_waddr),  64'h05);
        chk("coll.rgnt",   64'(rgnt),      64'h2);
        chk("coll.rvalid", 64'(xb_rvalid), 64'h1);
        chk("coll.raddr",  64'(xb_raddr),  64'h06);
        @(negedge clk); rreq = 2'b00; xb_rhit = 1'b1; xb_rdata = 32'h1234_5678; #1;
        chk("coll.rresp", 64'(rresp), 64'h2);
        chk("coll.rhit",  64'(rhit),  64'h1);
        chk("coll.rdata", 64'(rdata), 64'h1234_5678);
        chk("coll.rgnt0", 64'(rgnt),  64'h0);
        @(negedge clk); xb_wready = 1'b1; xb_rhit = 1'b0; #1;
        chk("coll.wack",     64'(wack),  64'h1);
        chk("coll.no_rresp", 64'(rresp), 64'h0);
        chk("coll.no_rdata", 64'(rdata), 64'h0);
        @(negedge clk); wreq = 4'h0;

        // ---- two consumers every cycle: alternate, one miss ----
        @(negedge clk); rreq = 2'b11; #1;
        chk("alt.gnt0", 64'(rgnt), 64'h1);
        @(negedge clk); xb_rhit = 1'b1; xb_rdata = 32'h0000_AAAA; #1;
        chk("alt.gnt1",   64'(rgnt),  64'h2);
        chk("alt.resp0",  64'(rresp), 64'h1);
        chk("alt.hit0",   64'(rhit),  64'h1);
        chk("alt.data0",  64'(rdata), 64'h0000_AAAA);
        @(negedge clk); xb_rhit = 1'b0; xb_rdata = 32'h0000_BBBB; #1;
        chk("alt.gnt2",   64'(rgnt),  64'h1);
        chk("alt.resp1",  64'(rresp), 64'h2);
        chk("alt.miss1",  64'(rhit),  64'h0);
        chk("alt.data1",  64'(rdata), 64'h0000_BBBB);
        @(negedge clk); rreq = 2'b00; xb_rhit = 1'b1; xb_rdata = 32'h0000_CCCC; #1;
        chk("alt.gnt3",   64'(rgnt),  64'h0);
        chk("alt.resp2",  64'(rresp), 64'h1);
        @(negedge clk); xb_rhit = 1'b0; xb_rdata = 32'h0;

        // ---- async reset mid-stall (wptr=1, so producer 2 is staged) ----
        wreq = 4'b0100; xb_wready = 1'b0;
        @(negedge clk); #1;
        chk("rst.pre_wvalid", 64'(xb_wvalid), 64'h1);
        chk("rst.pre_waddr",  64'(xb_waddr),  64'h12);
        #2 reset_n = 1'b0; #1;
        chk_idle_outputs("rst.async");
        @(negedge clk); reset_n = 1'b1; wreq = 4'b0011;
        @(negedge clk); xb_wready = 1'b1; #1;
        chk("rst.first_wack",  64'(wack),     64'h1);
        chk("rst.first_waddr", 64'(xb_waddr), 64'h05);
        @(negedge clk); wreq = 4'b0010; #1;
        chk("rst.second_wack", 64'(wack), 64'h2);
        @(negedge clk); wreq = 4'h0;

`ifdef ALPU_XBUF_ARB_PERF_EN
        // ---- perf counters: 3 accepts, 4 stalls, 1 miss, 2 collisions ----
        reset_n = 1'b0; xb_wready = 1'b0; #1;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); wreq = 4'b0111;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); rreq = (k <= 2) ? 2'b01 : 2'b00;
        end
        @(negedge clk); rreq = 2'b00; xb_wready = 1'b1;
        @(negedge clk); wreq = 4'b0110;
        @(negedge clk); wreq = 4'b0100;
        @(negedge clk); wreq = 4'b0000; xb_wready = 1'b0; rreq = 2'b10;
        @(negedge clk); rreq = 2'b00; xb_rhit = 1'b0;
        @(negedge clk); #1;
        chk("perf.wacc",   64'(p_wacc),   64'd3);
        chk("perf.wstall", 64'(p_wstall), 64'd4);
        chk("perf.rmiss",  64'(p_rmiss),  64'd1);
        chk("perf.rcoll",  64'(p_rcoll),  64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
